// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern, optional
// overlapping matches, a bit-valid qualifier and a saturating match counter.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_DEF = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               VC_W    = $clog2(PAT_W);
  localparam logic [VC_W-1:0]  VC_MAX  = VC_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-2:0] hist;
  logic [VC_W-1:0]  vcnt;
  logic [PAT_W-1:0] window;
  logic             match;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    window = {hist, in};
    match  = en & ~rst & ~load & (vcnt == VC_MAX) & (window == pat_r);
  end

  assign y = match;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= PAT_DEF;
      hist      <= '0;
      vcnt      <= '0;
      y_q       <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      // Pattern / history path: a load discards the bit presented alongside it.
      if (load) begin
        pat_r <= pat_in;
        hist  <= '0;
        vcnt  <= '0;
      end else if (en) begin
        y_q <= match;
        if (match && !overlap) begin
          hist <= '0;
          vcnt <= '0;
        end else begin
          hist <= window[PAT_W-2:0];
          if (vcnt != VC_MAX) vcnt <= vcnt + VC_W'(1);
        end
      end

      // Counter path: a clear wins over a match arriving in the same cycle.
      if (cnt_clr) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else if (match && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
        if (match_cnt == CNT_MAX - CNT_W'(1)) cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2): overlap, non-overlap,
// enable gaps, reload, counter saturation/clear and mid-pattern reset.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, in, load, overlap, cnt_clr;
  logic [3:0] pat_in;
  logic       y, y_q, cnt_sat;
  logic [1:0] match_cnt;

  int tests = 0;
  int fails = 0;

  seq_detector_param #(.PAT_W(4), .PAT_DEF(4'b1011), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .overlap(overlap), .cnt_clr(cnt_clr), .y(y), .y_q(y_q),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs applied after the falling edge; combinational y is valid on return.
  task automatic cyc(input logic en_i, input logic in_i, input logic ld_i, input logic clr_i);
    @(negedge clk);
    rst = 1'b0; en = en_i; in = in_i; load = ld_i; cnt_clr = clr_i;
    #1;
  endtask

  task automatic rst_cyc(input logic en_i, input logic in_i);
    @(negedge clk);
    rst = 1'b1; en = en_i; in = in_i; load = 1'b0; cnt_clr = 1'b0;
    #1;
  endtask

  logic [12:0] s_bits;
  logic [12:0] s_y;

  initial begin
    rst = 1'b1; en = 1'b0; in = 1'b0; load = 1'b0; cnt_clr = 1'b0;
    overlap = 1'b1; pat_in = 4'b0000;

    // Reset state, y forced low while rst is high
    rst_cyc(1'b0, 1'b0);
    rst_cyc(1'b1, 1'b1);
    chk("rst_y", y, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", match_cnt, 2'd0);
    chk("rst_sat", cnt_sat, 1'b0);
    chk("rst_yq", y_q, 1'b0);

    // Overlap mode: 1011011 -> matches at bits 4 and 7
    overlap = 1'b1;
    s_bits = 13'b0000001101101;   // LSB first: 1,0,1,1,0,1,1
    s_y    = 13'b0000001001000;   // matches at bits 4 and 7
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, s_bits[i], 1'b0, 1'b0);
      chk($sformatf("ovl_y%0d", i + 1), y, s_y[i]);
      if (i > 0) chk($sformatf("ovl_yq%0d", i + 1), y_q, s_y[i-1]);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovl_yq8", y_q, 1'b1);
    chk("ovl_cnt", match_cnt, 2'd2);

    // Non-overlap mode: 1011011 011 -> matches at bits 4 and 10
    rst_cyc(1'b0, 1'b0);
    overlap = 1'b0;
    s_bits = 13'b0001101101101;   // 1,0,1,1,0,1,1,0,1,1
    s_y    = 13'b0001000001000;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, s_bits[i], 1'b0, 1'b0);
      chk($sformatf("nov_y%0d", i + 1), y, s_y[i]);
      if (i == 7) chk("nov_cnt7", match_cnt, 2'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("nov_cnt10", match_cnt, 2'd2);

    // Enable gap: 1,0,1 then five idle cycles with toggling in, then 1
    rst_cyc(1'b0, 1'b0);
    overlap = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, (i % 2 == 0), 1'b0, 1'b0);
      chk($sformatf("gap_y%0d", i), y, 1'b0);
    end
    chk("gap_yq", y_q, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_last_y", y, 1'b1);

    // Reload: 0,0 accepted, then load 0000 with in=0, then four 0s
    rst_cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pat_in = 4'b0000;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("ld_cycle_y", y, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("ld_y%0d", i), y, (i == 4));
    end

    // Counter saturation with CNT_W=2: matches at bits 4, 7, 10, 13
    rst_cyc(1'b0, 1'b0);
    overlap = 1'b1;
    s_bits = 13'b1101101101101;
    s_y    = 13'b1001001001000;
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, s_bits[i], 1'b0, 1'b0);
      chk($sformatf("sat_y%0d", i + 1), y, s_y[i]);
      if (i == 7)  chk("sat_cnt2", match_cnt, 2'd2);
      if (i == 7)  chk("sat_flag2", cnt_sat, 1'b0);
      if (i == 10) chk("sat_cnt3", match_cnt, 2'd3);
      if (i == 10) chk("sat_flag3", cnt_sat, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt4", match_cnt, 2'd3);
    chk("sat_flag4", cnt_sat, 1'b1);
    // cnt_clr together with a match: match shows on y but is not counted
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_y", y, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_cnt", match_cnt, 2'd0);
    chk("clr_sat", cnt_sat, 1'b0);

    // Mid-pattern reset: load 1111, send 1,1,1, reset, then 1,0,1,1 against 1011
    pat_in = 4'b1111;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("mr_pre_y%0d", i), y, 1'b0);
    end
    rst_cyc(1'b1, 1'b1);
    chk("mr_rst_y", y, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mr_post1_y", y, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mr_post2_y", y, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mr_post3_y", y, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mr_post4_y", y, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mr_cnt", match_cnt, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
